// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and word geometry for the data-memory responder
package dmem_pkg;
   localparam int WORD_W    = 32;
   localparam int NUM_LANES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage: one synchronous byte-enabled write port, one asynchronous read port
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic                 clock,
   input  logic                 we,
   input  logic [NUM_LANES-1:0] be,
   input  logic [AW-1:0]        waddr,
   input  logic [WORD_W-1:0]    wdata,
   input  logic [AW-1:0]        raddr,
   output logic [WORD_W-1:0]    rdata
);
   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   // Contents deliberately survive reset.
   always_ff @(posedge clock) begin
      if (we) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with fixed wait latency
// Byte strobes (req_be) are present only when DMEM_BYTE_STROBE_EN is defined.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [31:0]          req_addr,
   input  logic [WORD_W-1:0]    req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
   input  logic [NUM_LANES-1:0] req_be,
`endif
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [WORD_W-1:0]    resp_rdata,
   output logic                 resp_err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

   state_t state, state_next;
   logic [3:0] cnt;

   logic                 cap_write, cap_err;
   logic [AW-1:0]        cap_idx;
   logic [WORD_W-1:0]    cap_wdata;
   logic [NUM_LANES-1:0] cap_be;

   logic                 accept, live_err, enter_resp, mem_we;
   logic [NUM_LANES-1:0] live_be, cur_be;
   logic                 cur_write, cur_err;
   logic [AW-1:0]        cur_idx;
   logic [WORD_W-1:0]    cur_wdata, rd_data;

`ifdef DMEM_BYTE_STROBE_EN
   assign live_be = req_be;
`else
   assign live_be = '1;
`endif

   assign accept   = req_valid && req_ready;
   assign live_err = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = (LATENCY == 0) ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt == 4'd0) state_next = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // With zero latency the commit edge is the accept edge, so IDLE uses the live request.
   always_comb begin
      cur_write = cap_write;
      cur_err   = cap_err;
      cur_idx   = cap_idx;
      cur_wdata = cap_wdata;
      cur_be    = cap_be;
      if (state == IDLE) begin
         cur_write = req_write;
         cur_err   = live_err;
         cur_idx   = req_addr[AW+1:2];
         cur_wdata = req_wdata;
         cur_be    = live_be;
      end
   end

   assign enter_resp = (state != RESP) && (state_next == RESP);
   assign mem_we     = enter_resp && cur_write && !cur_err && !reset;

   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clock (clock),
      .we    (mem_we),
      .be    (cur_be),
      .waddr (cur_idx),
      .wdata (cur_wdata),
      .raddr (cur_idx),
      .rdata (rd_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         cap_write  <= 1'b0;
         cap_err    <= 1'b0;
         cap_idx    <= '0;
         cap_wdata  <= '0;
         cap_be     <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            cap_write <= req_write;
            cap_err   <= live_err;
            cap_idx   <= req_addr[AW+1:2];
            cap_wdata <= req_wdata;
            cap_be    <= live_be;
         end
         if (accept && (LATENCY > 0)) cnt <= LAT_LOAD;
         else if ((state == WAIT) && (cnt != 4'd0)) cnt <= cnt - 4'd1;
         if (enter_resp) begin
            resp_err   <= cur_err;
            resp_rdata <= (cur_write || cur_err) ? '0 : rd_data;
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized scoreboard bench for dmem_responder
// Byte-strobe scenarios are included when DMEM_BYTE_STROBE_EN is defined.
`timescale 1ns/1ps
module tb_dmem_responder;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_ready = 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
   logic [3:0]  req_be = 4'hF;
`endif
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
      .req_be     (req_be),
`endif
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   logic [31:0] model_mem [DEPTH];
   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   bit          bp_hold = 0;
   bit          in_resp = 0;

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: word-addressed array, byte lanes merged under the strobe.
   function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] be);
      exp_t e;
      int   idx;
      e.err   = (a % 4 != 0) || ((a / 4) >= DEPTH);
      e.rdata = 32'h0;
      e.acc   = 0;
      if (!e.err) begin
         idx = int'(a / 4);
         if (w) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
         end else begin
            e.rdata = model_mem[idx];
         end
      end
      return e;
   endfunction

   // Called at posedge+2; returns at posedge+2 after the acceptance edge.
   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit track);
      exp_t       e;
      bit         done;
      logic [3:0] be_eff;
      done = 0;
`ifdef DMEM_BYTE_STROBE_EN
      be_eff = be;
      req_be = be;
`else
      be_eff = 4'hF;
`endif
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clock);
         if (req_ready === 1'b1) begin
            if (track) begin
               e = model(w, a, d, be_eff);
               e.acc = cyc;
               exp_q.push_back(e);
            end
            done = 1;
         end
         @(posedge clock);
         #2;
      end
      req_valid = 1'b0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL req_accept_timeout: req_ready never 1 for addr 0x%08h", a);
      end
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clock);
         if (exp_q.size() == 0 && !in_resp && resp_valid !== 1'b1) ok = 1;
         @(posedge clock);
         #2;
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d responses still pending", exp_q.size());
      end
   endtask

   // Scoreboard monitor: pops on the first cycle of each response, then checks holding.
   initial begin : monitor
      exp_t        e;
      logic [31:0] held_rdata;
      logic        held_err;
      held_rdata = '0;
      held_err   = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            in_resp = 0;
         end else if (resp_valid === 1'b1) begin
            if (!in_resp) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_resp: rdata 0x%08h err %0b, expected none", resp_rdata, resp_err);
               end else begin
                  e = exp_q.pop_front();
                  check("resp_rdata", resp_rdata, e.rdata);
                  check("resp_err", 32'(resp_err), 32'(e.err));
                  check("resp_latency", 32'(cyc - e.acc), 32'(LAT + 1));
               end
               held_rdata = resp_rdata;
               held_err   = resp_err;
               in_resp    = 1;
            end else begin
               check("hold_rdata", resp_rdata, held_rdata);
               check("hold_err", 32'(resp_err), 32'(held_err));
            end
            if (resp_ready === 1'b1) in_resp = 0;
         end
      end
   end

   initial forever begin
      @(posedge clock);
      #1;
      resp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
   end

   initial begin : stim
      logic [31:0] a;
      int          k;
      int          idx;

      repeat (3) @(posedge clock);
      #2;
      reset = 1'b0;
      @(negedge clock);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_resp_rdata", resp_rdata, 32'd0);
      check("reset_resp_err", 32'(resp_err), 32'd0);
      @(posedge clock);
      #2;

      for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 1);

      do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1);
      do_req(1'b0, 32'h10, 32'h0, 4'hF, 1);
      do_req(1'b0, 32'h13, 32'h0, 4'hF, 1);
      do_req(1'b1, 32'h22, 32'hCAFEF00D, 4'hF, 1);
      do_req(1'b0, 32'h20, 32'h0, 4'hF, 1);
      do_req(1'b0, 32'h400, 32'h0, 4'hF, 1);
      do_req(1'b0, 32'h3FC, 32'h0, 4'hF, 1);
`ifdef DMEM_BYTE_STROBE_EN
      do_req(1'b1, 32'h30, 32'h11223344, 4'hF, 1);
      do_req(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 1);
      do_req(1'b0, 32'h30, 32'h0, 4'hF, 1);
      do_req(1'b1, 32'h30, 32'h55667788, 4'b0000, 1);
      do_req(1'b0, 32'h30, 32'h0, 4'hF, 1);
`endif
      wait_drain();

      // Back-pressure: response held while an untracked store is offered.
      bp_hold    = 1;
      resp_ready = 1'b0;
      do_req(1'b0, 32'h10, 32'h0, 4'hF, 1);
      k = 0;
      for (int i = 0; i < 50 && k == 0; i++) begin
         @(negedge clock);
         if (resp_valid === 1'b1) k = 1;
      end
      check("bp_resp_seen", 32'(k), 32'd1);
      @(posedge clock);
      #2;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'h0BADF00D;
      repeat (5) begin
         @(negedge clock);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_resp_valid", 32'(resp_valid), 32'd1);
         @(posedge clock);
         #2;
      end
      req_valid = 1'b0;
      bp_hold   = 0;
      wait_drain();
      do_req(1'b0, 32'h10, 32'h0, 4'hF, 1);
      wait_drain();

      // Reset while the store waits: no write, outputs back to reset values.
      do_req(1'b1, 32'h8, 32'h12345678, 4'hF, 0);
      reset = 1'b1;
      @(posedge clock);
      #2;
      reset = 1'b0;
      @(negedge clock);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_resp_rdata", resp_rdata, 32'd0);
      check("abort_resp_err", 32'(resp_err), 32'd0);
      @(posedge clock);
      #2;
      do_req(1'b0, 32'h8, 32'h0, 4'hF, 1);
      wait_drain();

      for (int n = 0; n < 200; n++) begin
         k   = $urandom_range(0, 7);
         idx = $urandom_range(0, DEPTH - 1);
         if (k <= 5)      a = 32'(idx * 4);
         else if (k == 6) a = 32'(idx * 4 + $urandom_range(1, 3));
         else             a = $urandom | 32'h400;
         do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1);
      end
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
